// File: rtl/logmap_axil_regfile_if.sv
`default_nettype none
// ============================================================================
// Module  : logmap_axil_regfile_if
// Brief   : AXI4-Lite bus bundle between the interconnect master and the
//           logmap register file.
// Revision: 1.0 - initial release
// ============================================================================
interface logmap_axil_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/logmap_axil_regfile.sv
`default_nettype none
// ============================================================================
// Module  : logmap_axil_regfile
// Brief   : AXI4-Lite register file with byte strobes, read-only status
//           mapping and per-register write pulses. Define
//           LOGMAP_AXIL_SLVERR_EN for SLVERR on out-of-range/RO accesses.
// Revision: 1.0 - initial release
// ============================================================================
module logmap_axil_regfile #(
  parameter int                   DATA_WIDTH = 32,
  parameter int                   ADDR_WIDTH = 8,
  parameter int                   REG_COUNT  = 8,
  parameter logic [REG_COUNT-1:0] RO_MASK    = '0
) (
  input  wire logic                            S_AXI_ACLK,
  input  wire logic                            S_AXI_ARESET,
  logmap_axil_regfile_if.slave                 bus,
  output logic [REG_COUNT*DATA_WIDTH-1:0]      regs_o,
  input  wire logic [REG_COUNT*DATA_WIDTH-1:0] status_i,
  output logic [REG_COUNT-1:0]                 wr_pulse_o
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  // A single register still decodes one index bit so that bit counts as out of range.
  localparam int IDX_W    = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef LOGMAP_AXIL_SLVERR_EN
  localparam logic [1:0] RESP_ERR  = 2'b10;
`else
  localparam logic [1:0] RESP_ERR  = 2'b00;
`endif

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_LSB +: IDX_W];
  endfunction

  function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] a);
    return ((a >> (ADDR_LSB + IDX_W)) != '0) || (int'(a[ADDR_LSB +: IDX_W]) >= REG_COUNT);
  endfunction

  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
  logic                  r_ready_en;
  logic                  r_aw_held, r_aw_oor, r_w_held, r_bvalid;
  logic [IDX_W-1:0]      r_aw_idx, r_ar_idx;
  logic [DATA_WIDTH-1:0] r_w_data, r_rdata;
  logic [STRB_W-1:0]     r_w_strb;
  logic [1:0]            r_bresp, r_rresp;
  logic                  r_ar_held, r_ar_oor, r_rvalid;
  logic [REG_COUNT-1:0]  r_wr_pulse;

  logic                  w_awready, w_wready, w_arready;
  logic                  w_commit, w_aw_ro, w_wr_ok;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_unused;

  assign w_awready = r_ready_en && !r_aw_held && !r_bvalid;
  assign w_wready  = r_ready_en && !r_w_held  && !r_bvalid;
  assign w_arready = r_ready_en && !r_ar_held && !r_rvalid;
  assign w_commit  = r_aw_held && r_w_held;
  assign w_wr_ok   = w_commit && !r_aw_oor && !w_aw_ro;

  always_comb begin
    w_aw_ro   = 1'b0;
    w_rd_data = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (r_aw_idx == IDX_W'(i)) w_aw_ro = RO_MASK[i];
      if (!r_ar_oor && r_ar_idx == IDX_W'(i))
        w_rd_data = RO_MASK[i] ? status_i[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
      r_ready_en <= 1'b0;
      r_aw_held  <= 1'b0;
      r_aw_idx   <= '0;
      r_aw_oor   <= 1'b0;
      r_w_held   <= 1'b0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_ar_held  <= 1'b0;
      r_ar_idx   <= '0;
      r_ar_oor   <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
      r_wr_pulse <= '0;
    end else begin
      r_ready_en <= 1'b1;
      r_wr_pulse <= '0;

      if (bus.awvalid && w_awready) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= addr_idx(bus.awaddr);
        r_aw_oor  <= addr_oor(bus.awaddr);
      end
      if (bus.wvalid && w_wready) begin
        r_w_held <= 1'b1;
        r_w_data <= bus.wdata;
        r_w_strb <= bus.wstrb;
      end

      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= (r_aw_oor || w_aw_ro) ? RESP_ERR : RESP_OKAY;
        for (int i = 0; i < REG_COUNT; i++) begin
          if (w_wr_ok && r_aw_idx == IDX_W'(i)) begin
            r_wr_pulse[i] <= 1'b1;
            for (int b = 0; b < STRB_W; b++)
              if (r_w_strb[b]) r_regs[i][b*8 +: 8] <= r_w_data[b*8 +: 8];
          end
        end
      end else if (r_bvalid && bus.bready) begin
        r_bvalid <= 1'b0;
      end

      if (bus.arvalid && w_arready) begin
        r_ar_held <= 1'b1;
        r_ar_idx  <= addr_idx(bus.araddr);
        r_ar_oor  <= addr_oor(bus.araddr);
      end
      if (r_ar_held) begin
        r_ar_held <= 1'b0;
        r_rvalid  <= 1'b1;
        r_rdata   <= w_rd_data;
        r_rresp   <= r_ar_oor ? RESP_ERR : RESP_OKAY;
      end else if (r_rvalid && bus.rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign bus.awready = w_awready;
  assign bus.wready  = w_wready;
  assign bus.bvalid  = r_bvalid;
  assign bus.bresp   = r_bresp;
  assign bus.arready = w_arready;
  assign bus.rvalid  = r_rvalid;
  assign bus.rdata   = r_rdata;
  assign bus.rresp   = r_rresp;
  assign wr_pulse_o  = r_wr_pulse;

  generate
    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_regs_o
      assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
    end
  endgenerate

  // Protection bits, sub-word address bits and non-RO status lanes carry no meaning here.
  assign w_unused = ^{bus.awprot, bus.arprot, bus.awaddr[ADDR_LSB-1:0],
                      bus.araddr[ADDR_LSB-1:0], status_i};

endmodule
`default_nettype wire
